// File: rtl/muxseq_pkg.sv
// Shared types and constants for the muxseq channel multiplexer/scanner.
package muxseq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/muxseq_sel.sv
// Combinational N_CH:1 W-bit selector; an out-of-range index yields zero data and hit_o=0.
module muxseq_sel #(
    parameter int N_CH  = 16,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] din_i,
    input  logic [SEL_W-1:0]  idx_i,
    output logic [W-1:0]      data_o,
    output logic              hit_o
);

    // One-hot compare per channel so an index beyond N_CH matches nothing
    always_comb begin
        data_o = {W{1'b0}};
        hit_o  = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (idx_i == SEL_W'(c)) begin
                data_o = din_i[c*W +: W];
                hit_o  = 1'b1;
            end else begin
                hit_o  = hit_o;
            end
        end
    end

endmodule

// File: rtl/muxseq.sv
// Registered N-channel mux with manual select and ascending scan mode, valid/ready output slot.
// Optional channel mask for scans is enabled with `define MUXSEQ_MASK_EN.
module muxseq
    import muxseq_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] din,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic              req,
    input  logic              start,
`ifdef MUXSEQ_MASK_EN
    input  logic [N_CH-1:0]   ch_mask,
`endif
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [W-1:0]       data_q, data_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               pend_q, pend_d;

    logic [N_CH-1:0]    mask_s;
    logic [SEL_W:0]     first_s;
    logic [SEL_W:0]     next_s;
    logic [SEL_W-1:0]   scan_idx_s;
    logic [SEL_W-1:0]   idx_s;
    logic [W-1:0]       sel_data_s;
    logic               hit_s;
    logic               slot_free_s;
    logic               load_s;

    // Lowest included channel at or above lo, as {found, index}
    function automatic logic [SEL_W:0] find_incl(input logic [N_CH-1:0] m, input int lo);
        logic [SEL_W:0] r;
        r = {(SEL_W+1){1'b0}};
        for (int c = N_CH - 1; c >= 0; c--) begin
            if ((c >= lo) && m[c]) begin
                r = {1'b1, SEL_W'(c)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

`ifdef MUXSEQ_MASK_EN
    assign mask_s = ch_mask;
`else
    assign mask_s = {N_CH{1'b1}};
`endif

    assign slot_free_s = ~valid_q | out_ready;

    // Channel index feeding the selector and the scan successor search
    always_comb begin
        first_s    = find_incl(mask_s, 0);
        scan_idx_s = (state_q == SCAN) ? ptr_q : first_s[SEL_W-1:0];
        next_s     = find_incl(mask_s, int'(scan_idx_s) + 1);
        if ((state_q == IDLE) && (mode == MODE_MANUAL)) begin
            idx_s = sel;
        end else begin
            idx_s = scan_idx_s;
        end
    end

    muxseq_sel #(
        .N_CH  (N_CH),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_sel (
        .din_i  (din),
        .idx_i  (idx_s),
        .data_o (sel_data_s),
        .hit_o  (hit_s)
    );

    // FSM next state and output-slot next values
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q & ~out_ready;
        err_d   = 1'b0;
        done_d  = pend_q;
        pend_d  = 1'b0;
        load_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mode == MODE_MANUAL) begin
                    if (req && slot_free_s) begin
                        load_s = 1'b1;
                        err_d  = ~hit_s;
                    end else begin
                        load_s = 1'b0;
                    end
                end else if (start) begin
                    // First word loads in the start cycle so it is valid one cycle later
                    if (!first_s[SEL_W]) begin
                        pend_d = 1'b1;
                    end else if (slot_free_s) begin
                        load_s = 1'b1;
                        if (next_s[SEL_W]) begin
                            ptr_d   = next_s[SEL_W-1:0];
                            state_d = SCAN;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        ptr_d   = first_s[SEL_W-1:0];
                        state_d = SCAN;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            SCAN: begin
                if (slot_free_s) begin
                    load_s = 1'b1;
                    if (next_s[SEL_W]) begin
                        ptr_d = next_s[SEL_W-1:0];
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            DRAIN: begin
                if (slot_free_s) begin
                    state_d = IDLE;
                    ptr_d   = {SEL_W{1'b0}};
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = {SEL_W{1'b0}};
            end
        endcase
        if (load_s) begin
            data_d  = sel_data_s;
            ch_d    = idx_s;
            valid_d = 1'b1;
        end else begin
            data_d  = data_q;
            ch_d    = ch_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= {SEL_W{1'b0}};
            data_q  <= {W{1'b0}};
            ch_q    <= {SEL_W{1'b0}};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;
    assign err       = err_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_muxseq.sv
// Scoreboard bench for muxseq: 16x8 instance for manual/scan/backpressure/reset, 12x8 instance for range errors.
module tb_muxseq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] din;
    logic         mode;
    logic [3:0]   sel;
    logic         req;
    logic         req12;
    logic         start;
    logic         out_ready;
`ifdef MUXSEQ_MASK_EN
    logic [15:0]  ch_mask;
`endif
    logic [7:0]   out_data;
    logic [3:0]   out_ch;
    logic         out_valid;
    logic         busy;
    logic         done;
    logic         err;
    logic [7:0]   out_data12;
    logic [3:0]   out_ch12;
    logic         out_valid12;
    logic         busy12;
    logic         done12;
    logic         err12;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [11:0]  sb_q[$];
    logic [11:0]  exp_w;
    logic         prev_hold = 1'b0;
    logic [11:0]  prev_word = 12'd0;

    always #5 clk = ~clk;

    muxseq #(.N_CH(16), .W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .mode      (mode),
        .sel       (sel),
        .req       (req),
        .start     (start),
`ifdef MUXSEQ_MASK_EN
        .ch_mask   (ch_mask),
`endif
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    muxseq #(.N_CH(12), .W(8)) u_dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din[95:0]),
        .mode      (mode),
        .sel       (sel),
        .req       (req12),
        .start     (1'b0),
`ifdef MUXSEQ_MASK_EN
        .ch_mask   (ch_mask[11:0]),
`endif
        .out_data  (out_data12),
        .out_ch    (out_ch12),
        .out_valid (out_valid12),
        .out_ready (out_ready),
        .busy      (busy12),
        .done      (done12),
        .err       (err12)
    );

    // Scoreboard pop on every handshake of the 16-channel instance, plus hold-stability under backpressure
    always @(negedge clk) begin
        if (rst_n && prev_hold) begin
            n_checks++;
            if ({out_ch, out_data} !== prev_word) begin
                n_fail++;
                $display("FAIL bp_stable: got ch=%0d data=%h, required ch=%0d data=%h",
                         out_ch, out_data, prev_word[11:8], prev_word[7:0]);
            end
        end
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got ch=%0d data=%h, required no word", out_ch, out_data);
            end else begin
                exp_w = sb_q.pop_front();
                if ({out_ch, out_data} !== exp_w) begin
                    n_fail++;
                    $display("FAIL sb_word: got ch=%0d data=%h, required ch=%0d data=%h",
                             out_ch, out_data, exp_w[11:8], exp_w[7:0]);
                end
            end
        end
        prev_hold = rst_n && out_valid && !out_ready;
        prev_word = {out_ch, out_data};
    end

    task automatic push_word(input int c);
        sb_q.push_back({4'(c), 8'(8'h10 + c)});
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy, done, err, out_ch, out_data} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b b=%b d=%b e=%b ch=%0d data=%h, required all 0",
                     out_valid, busy, done, err, out_ch, out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy, done, err} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got v=%b b=%b d=%b e=%b, required 0000", out_valid, busy, done, err);
        end
    endtask

    task automatic test_manual();
        @(posedge clk); #1;
        mode = 1'b0; sel = 4'd5; req = 1'b1; out_ready = 1'b1;
        push_word(5);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_ch, out_data, err} !== {1'b1, 4'd5, 8'h15, 1'b0}) begin
            n_fail++;
            $display("FAIL manual_word: got v=%b ch=%0d data=%h err=%b, required v=1 ch=5 data=15 err=0",
                     out_valid, out_ch, out_data, err);
        end
        // start with mode=0 must be ignored
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL manual_ignore_start: got v=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_scan();
        for (int c = 0; c < 16; c++) push_word(c);
        @(posedge clk); #1;
        mode = 1'b1; out_ready = 1'b1; start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({busy, done, out_valid} !== {(k <= 16), (k == 17), (k <= 16)}) begin
                n_fail++;
                $display("FAIL scan_k%0d: got busy=%b done=%b v=%b, required %b %b %b",
                         k, busy, done, out_valid, (k <= 16), (k == 17), (k <= 16));
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scan_left: got %0d words pending, required 0", sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 16; c++) push_word(c);
        @(posedge clk); #1;
        mode = 1'b1; out_ready = 1'b1; start = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            out_ready = !((k >= 8) && (k <= 10));
            @(negedge clk);
            n_checks++;
            if ({busy, done} !== {(k <= 19), (k == 20)}) begin
                n_fail++;
                $display("FAIL bp_k%0d: got busy=%b done=%b, required %b %b", k, busy, done, (k <= 19), (k == 20));
            end
            if ((k >= 8) && (k <= 11)) begin
                n_checks++;
                if ({out_valid, out_ch} !== {1'b1, 4'd7}) begin
                    n_fail++;
                    $display("FAIL bp_hold_k%0d: got v=%b ch=%0d, required v=1 ch=7", k, out_valid, out_ch);
                end
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_left: got %0d words pending, required 0", sb_q.size());
        end
    endtask

`ifdef MUXSEQ_MASK_EN
    task automatic test_mask();
        push_word(0); push_word(5); push_word(10); push_word(15);
        @(posedge clk); #1;
        ch_mask = 16'h8421; mode = 1'b1; out_ready = 1'b1; start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({out_valid, done} !== {(k <= 4), (k == 5)}) begin
                n_fail++;
                $display("FAIL mask_k%0d: got v=%b done=%b, required %b %b", k, out_valid, done, (k <= 4), (k == 5));
            end
        end
        @(posedge clk); #1;
        ch_mask = 16'h0000; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({out_valid, busy, done} !== {1'b0, 1'b0, (k == 2)}) begin
                n_fail++;
                $display("FAIL mask0_k%0d: got v=%b busy=%b done=%b, required 0 0 %b", k, out_valid, busy, done, (k == 2));
            end
        end
        ch_mask = 16'hFFFF;
    endtask
`endif

    task automatic test_error();
        @(posedge clk); #1;
        mode = 1'b0; out_ready = 1'b1; sel = 4'd13; req12 = 1'b1;
        @(posedge clk); #1;
        req12 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid12, out_ch12, out_data12, err12} !== {1'b1, 4'd13, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL err_word: got v=%b ch=%0d data=%h err=%b, required v=1 ch=13 data=00 err=1",
                     out_valid12, out_ch12, out_data12, err12);
        end
        @(posedge clk); #1;
        sel = 4'd11; req12 = 1'b1;
        @(posedge clk); #1;
        req12 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid12, out_ch12, out_data12, err12} !== {1'b1, 4'd11, 8'h1B, 1'b0}) begin
            n_fail++;
            $display("FAIL err_inrange: got v=%b ch=%0d data=%h err=%b, required v=1 ch=11 data=1b err=0",
                     out_valid12, out_ch12, out_data12, err12);
        end
    endtask

    task automatic test_reset_mid_scan();
        for (int c = 0; c <= 4; c++) push_word(c);
        @(posedge clk); #1;
        mode = 1'b1; out_ready = 1'b1; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_ch, busy} !== {1'b1, 4'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_pre: got v=%b ch=%0d busy=%b, required v=1 ch=4 busy=1", out_valid, out_ch, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, done, err, out_ch, out_data} !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b b=%b d=%b e=%b ch=%0d data=%h, required all 0",
                     out_valid, busy, done, err, out_ch, out_data);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 1) rst_n = 1'b1;
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_done: got done=%b, required 0", done);
            end
        end
        test_scan();
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 4'd0; req = 1'b0; req12 = 1'b0;
        start = 1'b0; out_ready = 1'b1;
`ifdef MUXSEQ_MASK_EN
        ch_mask = 16'hFFFF;
`endif
        for (int c = 0; c < 16; c++) din[c*8 +: 8] = 8'(8'h10 + c);
        @(posedge clk);
        test_reset();
        test_manual();
        test_scan();
        test_backpressure();
`ifdef MUXSEQ_MASK_EN
        test_mask();
`endif
        test_error();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muxseq.md
# muxseq

Parametrised, registered N-channel W-bit multiplexer with a manual-select mode and an automatic scan mode. It generalises the fixed 16:1 single-bit gate-level multiplexer and puts a one-entry output register with a valid/ready handshake behind the select logic. In scan mode it serialises all channels onto one output stream, tagged with the channel index. It sits between parallel sources (sensor banks, register files) and a single serial consumer.

## Interface
Parameters:
- N_CH, 16, number of input channels (≥2).
- W, 1, data width per channel.
- SEL_W, $clog2(N_CH), channel index width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- din  in  N_CH*W  channel c occupies bits [c*W +: W].
- mode  in  1  0 = manual, 1 = scan; sampled only when a command is accepted.
- sel  in  SEL_W  manual-mode channel index.
- req  in  1  manual-mode capture request (level, one capture per accepted cycle).
- start  in  1  scan-mode start request.
- out_data  out  W  registered selected data.
- out_ch  out  SEL_W  channel index of out_data.
- out_valid  out  1  out_data/out_ch valid.
- out_ready  in  1  consumer accept.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse, scan complete.
- err  out  1  one-cycle pulse, manual sel ≥ N_CH.
- ch_mask  in  N_CH  only with MUXSEQ_MASK_EN; 1 = channel included in scan.

## Operation
- Output slot is free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
- A load happens only when the slot is free. A load writes out_data, out_ch and sets out_valid. If the slot is free and nothing loads, out_valid clears.
- FSM states: IDLE, SCAN, DRAIN.
- IDLE, mode=0, req=1, slot free: load din[sel], out_ch=sel. If sel ≥ N_CH, load zero data and pulse err.
- IDLE, mode=1, start=1: go to SCAN, ptr = first included channel. With mask enabled and an all-zero mask, go straight to IDLE and pulse done next cycle; no words are emitted.
- SCAN, slot free: load din[ptr], out_ch=ptr, advance ptr to the next included channel. After loading the last included channel, go to DRAIN.
- DRAIN: wait for the last word's handshake, then go to IDLE and pulse done the following cycle.
- Ignored in SCAN/DRAIN: req, start, mode changes, sel. Ignored in IDLE: start with mode=0, req with mode=1.
- busy = (state ≠ IDLE).
- din is sampled at the load cycle, not at the start cycle.
- ptr never wraps within a scan. A scan visits each included channel exactly once, in ascending order.

## Timing
- Reset values: out_data=0, out_ch=0, out_valid=0, busy=0, done=0, err=0, state=IDLE, ptr=0.
- Reset mid-scan aborts immediately. No done pulse follows.
- Manual latency: req accepted at cycle t → out_valid at t+1.
- Scan latency: start at t → first word valid at t+1. With out_ready held at 1, words follow back-to-back, one per cycle. With K included channels, the last word is at t+K and done=1 at t+K+1, the same cycle busy falls.
- Backpressure: out_data/out_ch are stable while out_valid=1 and out_ready=0.
- err is asserted in the cycle the zero word becomes valid.

## Configuration
- MUXSEQ_MASK_EN defined: the ch_mask port exists, and scan skips channels whose mask bit is 0. ch_mask is sampled each time ptr advances.
- MUXSEQ_MASK_EN undefined: there is no ch_mask port, and all N_CH channels are scanned.
- Manual mode ignores the mask in both builds.

## Structure
- Package muxseq_pkg holds:
  - state enum {IDLE, SCAN, DRAIN};
  - constants MODE_MANUAL=1'b0 and MODE_SCAN=1'b1.
- Sub-module muxseq_sel: purely combinational N_CH:1 W-bit selector. It takes din and an index and returns zero for an out-of-range index. It is instantiated once and driven by sel or ptr.

## Test plan
- Manual: N_CH=16, W=8, din[c]=8'h10+c, sel=5, req one cycle → next cycle out_valid=1, out_data=8'h15, out_ch=5.
- Scan, out_ready=1: start at t → out_ch 0..15 on cycles t+1..t+16, done pulse at t+17, busy high on t+1..t+16.
- Backpressure: out_ready=0 for 3 cycles during a scan at ch 7 → ch 7 held stable, no word lost or duplicated, done delayed by 3 cycles.
- Mask build: ch_mask=16'h8421 → words for ch 0, 5, 10, 15 only, then done. ch_mask=0 → done at t+2, no out_valid.
- Error: N_CH=12, sel=13, req → out_data=0, out_ch=13, err pulse.
- Reset: rst_n low during scan at ch 4 → all outputs reset immediately, no done. A fresh start afterwards restarts at ch 0.
